// File: rtl/kgp_rf_pkg.sv
// Shared defaults and types for the KGP-RISC register file slice.
package kgp_rf_pkg;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned HI_REG_DEF = 19;
  localparam int unsigned LO_REG_DEF = 20;

  typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
endpackage

// File: rtl/reg_busy_tracker.sv
// Per-register busy scoreboard: issue sets, writeback clears, set wins on conflict.
module reg_busy_tracker
  import kgp_rf_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter bit          ZERO_REG = 1'b1,
  parameter int unsigned HI_REG   = HI_REG_DEF,
  parameter int unsigned LO_REG   = LO_REG_DEF,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              pair_en,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_addr,
  input  logic              issue_pair,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic              rd_busy_a,
  output logic              rd_busy_b,
  output logic              issue_err
);
  localparam int unsigned NREGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] HI_A = HI_REG[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] LO_A = LO_REG[ADDR_W-1:0];

  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] set_vec;
  logic [NREGS-1:0] clr_vec;

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (wr_en) clr_vec[wr_addr] = 1'b1;
    if (pair_en) begin
      clr_vec[HI_A] = 1'b1;
      clr_vec[LO_A] = 1'b1;
    end
    if (issue_en) begin
      if (issue_pair) begin
        set_vec[HI_A] = 1'b1;
        set_vec[LO_A] = 1'b1;
      end else if (!(ZERO_REG && issue_addr == '0)) begin
        set_vec[issue_addr] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy      <= '0;
      issue_err <= 1'b0;
    end else begin
      busy      <= (busy & ~clr_vec) | set_vec;
      issue_err <= |(set_vec & busy & ~clr_vec);
    end
  end

  // With bypass a register being written back this cycle is already free to read.
  always_comb begin
    rd_busy_a = busy[rd_addr_a];
    rd_busy_b = busy[rd_addr_b];
    if (BYPASS) begin
      rd_busy_a = busy[rd_addr_a] & ~clr_vec[rd_addr_a];
      rd_busy_b = busy[rd_addr_b] & ~clr_vec[rd_addr_b];
    end
  end
endmodule

// File: rtl/reg_file_sb.sv
// Register file with two read ports, one general write port, a HI/LO pair write and busy scoreboard.
module reg_file_sb
  import kgp_rf_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter bit          ZERO_REG = 1'b1,
  parameter int unsigned HI_REG   = HI_REG_DEF,
  parameter int unsigned LO_REG   = LO_REG_DEF,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              pair_en,
  input  logic [DATA_W-1:0] pair_hi,
  input  logic [DATA_W-1:0] pair_lo,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  output logic              rd_busy_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_busy_b,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_addr,
  input  logic              issue_pair,
  output logic              issue_err
);
  localparam int unsigned NREGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] HI_A = HI_REG[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] LO_A = LO_REG[ADDR_W-1:0];

  logic [DATA_W-1:0] regs [NREGS];

  // Pair writes are issued last so they override a general write to HI/LO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      if (wr_en && !(ZERO_REG && wr_addr == '0)) regs[wr_addr] <= wr_data;
      if (pair_en) begin
        regs[HI_A] <= pair_hi;
        regs[LO_A] <= pair_lo;
      end
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] val;
    val = regs[addr];
    if (BYPASS) begin
      if (wr_en && wr_addr == addr) val = wr_data;
      if (pair_en && addr == HI_A) val = pair_hi;
      if (pair_en && addr == LO_A) val = pair_lo;
    end
    if (ZERO_REG && addr == '0) val = '0;
    return val;
  endfunction

  always_comb begin
    rd_data_a = read_port(rd_addr_a);
    rd_data_b = read_port(rd_addr_b);
  end

  reg_busy_tracker #(
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG),
    .HI_REG  (HI_REG),
    .LO_REG  (LO_REG),
    .BYPASS  (BYPASS)
  ) u_busy (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .pair_en   (pair_en),
    .issue_en  (issue_en),
    .issue_addr(issue_addr),
    .issue_pair(issue_pair),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_busy_a (rd_busy_a),
    .rd_busy_b (rd_busy_b),
    .issue_err (issue_err)
  );
endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: bypass and non-bypass instances against a behavioural register/scoreboard model.
module tb_reg_file_sb;
  import kgp_rf_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0, pair_en = 1'b0, issue_en = 1'b0, issue_pair = 1'b0;
  reg_addr_t   wr_addr = '0, rd_addr_a = '0, rd_addr_b = '0, issue_addr = '0;
  logic [31:0] wr_data = '0, pair_hi = '0, pair_lo = '0;

  logic [31:0] d_a1, d_b1, d_a0, d_b0;
  logic        b_a1, b_b1, b_a0, b_b0, err1, err0;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_mem  [32];
  bit          m_busy [32];
  bit          m_err;

  always #5 clk = ~clk;

  reg_file_sb #(.BYPASS(1'b1)) u_byp (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .pair_en(pair_en), .pair_hi(pair_hi), .pair_lo(pair_lo),
    .rd_addr_a(rd_addr_a), .rd_data_a(d_a1), .rd_busy_a(b_a1),
    .rd_addr_b(rd_addr_b), .rd_data_b(d_b1), .rd_busy_b(b_b1),
    .issue_en(issue_en), .issue_addr(issue_addr), .issue_pair(issue_pair), .issue_err(err1));

  reg_file_sb #(.BYPASS(1'b0)) u_nobyp (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .pair_en(pair_en), .pair_hi(pair_hi), .pair_lo(pair_lo),
    .rd_addr_a(rd_addr_a), .rd_data_a(d_a0), .rd_busy_a(b_a0),
    .rd_addr_b(rd_addr_b), .rd_data_b(d_b0), .rd_busy_b(b_b0),
    .issue_en(issue_en), .issue_addr(issue_addr), .issue_pair(issue_pair), .issue_err(err0));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit cleared_now(input int r);
    return (wr_en && int'(wr_addr) == r) || (pair_en && (r == 19 || r == 20));
  endfunction

  function automatic logic [31:0] exp_rd(input int r, input bit byp);
    if (r == 0) return 32'h0;
    if (byp && pair_en && r == 19) return pair_hi;
    if (byp && pair_en && r == 20) return pair_lo;
    if (byp && wr_en && int'(wr_addr) == r) return wr_data;
    return m_mem[r];
  endfunction

  function automatic bit exp_busy(input int r, input bit byp);
    return m_busy[r] && !(byp && cleared_now(r));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
    m_err = 1'b0;
  endtask

  task automatic model_edge();
    logic [31:0] nm [32];
    bit          nb [32];
    bit          ne;
    bit          set;
    ne = 1'b0;
    for (int i = 0; i < 32; i++) begin
      set = issue_en && (issue_pair ? (i == 19 || i == 20) : (i == int'(issue_addr) && i != 0));
      if (set && m_busy[i] && !cleared_now(i)) ne = 1'b1;
      nb[i] = set ? 1'b1 : (cleared_now(i) ? 1'b0 : m_busy[i]);
      nm[i] = m_mem[i];
      if (wr_en && int'(wr_addr) == i && i != 0) nm[i] = wr_data;
      if (pair_en && i == 19) nm[i] = pair_hi;
      if (pair_en && i == 20) nm[i] = pair_lo;
    end
    for (int i = 0; i < 32; i++) begin
      m_mem[i]  = nm[i];
      m_busy[i] = nb[i];
    end
    m_err = ne;
  endtask

  task automatic check_comb();
    chk("rd_a_byp",   d_a1, exp_rd(int'(rd_addr_a), 1'b1));
    chk("rd_b_byp",   d_b1, exp_rd(int'(rd_addr_b), 1'b1));
    chk("rd_a_nobyp", d_a0, exp_rd(int'(rd_addr_a), 1'b0));
    chk("rd_b_nobyp", d_b0, exp_rd(int'(rd_addr_b), 1'b0));
    chk("busy_a_byp",   32'(b_a1), 32'(exp_busy(int'(rd_addr_a), 1'b1)));
    chk("busy_b_byp",   32'(b_b1), 32'(exp_busy(int'(rd_addr_b), 1'b1)));
    chk("busy_a_nobyp", 32'(b_a0), 32'(exp_busy(int'(rd_addr_a), 1'b0)));
    chk("busy_b_nobyp", 32'(b_b0), 32'(exp_busy(int'(rd_addr_b), 1'b0)));
  endtask

  task automatic step();
    #1;
    check_comb();
    @(posedge clk);
    model_edge();
    #1;
    chk("err_byp",   32'(err1), 32'(m_err));
    chk("err_nobyp", 32'(err0), 32'(m_err));
  endtask

  task automatic idle();
    wr_en = 1'b0; pair_en = 1'b0; issue_en = 1'b0; issue_pair = 1'b0;
  endtask

  function automatic reg_addr_t pick_addr();
    case ($urandom_range(0, 5))
      0: return reg_addr_t'(0);
      1: return reg_addr_t'(19);
      2: return reg_addr_t'(20);
      default: return reg_addr_t'($urandom_range(0, 31));
    endcase
  endfunction

  task automatic random_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      wr_en      = ($urandom_range(0, 1) == 1);
      wr_addr    = pick_addr();
      wr_data    = $urandom;
      pair_en    = ($urandom_range(0, 4) == 0);
      pair_hi    = $urandom;
      pair_lo    = $urandom;
      issue_en   = ($urandom_range(0, 2) == 0);
      issue_pair = ($urandom_range(0, 3) == 0);
      issue_addr = pick_addr();
      rd_addr_a  = pick_addr();
      rd_addr_b  = pick_addr();
      step();
    end
  endtask

  initial begin
    model_reset();
    #1 rst = 1'b1;
    #2;
    chk("reset_rd_a", d_a1, 32'h0);
    chk("reset_busy_a", 32'(b_a1), 32'h0);
    chk("reset_err", 32'(err1), 32'h0);
    #5 rst = 1'b0;

    // write with same-cycle read of r7
    wr_en = 1'b1; wr_addr = 7; wr_data = 32'h1234; rd_addr_a = 7; rd_addr_b = 7;
    #1;
    chk("bypass_r7", d_a1, 32'h1234);
    chk("nobypass_r7_old", d_a0, 32'h0);
    step();
    idle();
    #1;
    chk("r7_after_edge_byp", d_a1, 32'h1234);
    chk("r7_after_edge_nobyp", d_a0, 32'h1234);

    // r0 write dropped
    wr_en = 1'b1; wr_addr = 0; wr_data = 32'hFFFF_FFFF; rd_addr_a = 0;
    #1;
    chk("r0_before_edge", d_a1, 32'h0);
    step();
    idle();
    #1;
    chk("r0_after_edge", d_a1, 32'h0);

    // pair write wins over general write to HI
    pair_en = 1'b1; pair_hi = 32'hAAAA_0001; pair_lo = 32'h5555_0002;
    wr_en = 1'b1; wr_addr = 19; wr_data = 32'h77; rd_addr_a = 19; rd_addr_b = 20;
    step();
    idle();
    #1;
    chk("pair_r19", d_a1, 32'hAAAA_0001);
    chk("pair_r20", d_b0, 32'h5555_0002);

    // pair issue then pair writeback
    issue_en = 1'b1; issue_pair = 1'b1;
    step();
    idle();
    rd_addr_a = 19;
    #1;
    chk("pair_busy_byp", 32'(b_a1), 32'h1);
    chk("pair_busy_nobyp", 32'(b_a0), 32'h1);
    pair_en = 1'b1; pair_hi = 32'h1; pair_lo = 32'h2;
    #1;
    chk("pair_clear_same_cycle_byp", 32'(b_a1), 32'h0);
    chk("pair_clear_same_cycle_nobyp", 32'(b_a0), 32'h1);
    step();
    idle();
    #1;
    chk("pair_clear_after_edge", 32'(b_a0), 32'h0);

    // double issue of r9, then issue+writeback conflict
    issue_en = 1'b1; issue_addr = 9; rd_addr_a = 9;
    step();
    #1;
    chk("single_issue_no_err", 32'(err1), 32'h0);
    step();
    chk("double_issue_err", 32'(err1), 32'h1);
    idle();
    step();
    chk("err_one_cycle", 32'(err1), 32'h0);
    issue_en = 1'b1; issue_addr = 9; wr_en = 1'b1; wr_addr = 9; wr_data = 32'h99;
    step();
    chk("issue_cleared_no_err", 32'(err1), 32'h0);
    idle();
    #1;
    chk("set_wins_busy", 32'(b_a1), 32'h1);
    wr_en = 1'b1; wr_addr = 9; wr_data = 32'h100;
    step();
    idle();

    random_cycles(400);

    // asynchronous reset mid-run
    idle();
    wr_en = 1'b1; wr_addr = 5; wr_data = 32'hDEAD_BEEF;
    issue_en = 1'b1; issue_addr = 6;
    step();
    idle();
    rd_addr_a = 5; rd_addr_b = 6;
    #1;
    chk("r5_written", d_a1, 32'hDEAD_BEEF);
    chk("r6_busy", 32'(b_b1), 32'h1);
    #1 rst = 1'b1;
    model_reset();
    #1;
    chk("async_rst_r5_byp", d_a1, 32'h0);
    chk("async_rst_r5_nobyp", d_a0, 32'h0);
    chk("async_rst_busy_b", 32'(b_b1), 32'h0);
    chk("async_rst_busy_b_nobyp", 32'(b_b0), 32'h0);
    #2 rst = 1'b0;

    random_cycles(200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
